// File: rtl/select_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for the shared output mux.
// A grant is held for a whole transfer, then followed by one forced-idle gap cycle.
module select_arbiter #(
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned HOLD_LIMIT    = 0,
  parameter int unsigned COUNTER_WIDTH = 16,
  localparam int unsigned IdxW         = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] request,
  input  logic              transferDone,
  output logic [INPUTS-1:0] grant,
  output logic              grantValid,
  output logic [IdxW-1:0]   grantIndex,
  output logic              timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [COUNTER_WIDTH-1:0] HoldLast = COUNTER_WIDTH'(HOLD_LIMIT - 1);

  state_e                   state_q, state_d;
  logic [INPUTS-1:0]        grant_q, grant_d;
  logic                     valid_q;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;

  logic                     win_found;
  logic [IdxW-1:0]          win_idx;
  logic [IdxW-1:0]          cand_idx;
  int unsigned              cand;
  logic                     hold_hit;
  logic                     release_grant;

  // Search upward from the pointer, wrapping at INPUTS-1; the first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= INPUTS) begin
        cand = cand - INPUTS;
      end
      cand_idx = cand[IdxW-1:0];
      if (!win_found && request[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign hold_hit      = (HOLD_LIMIT != 0) && (cnt_q == HoldLast);
  assign release_grant = !request[idx_q] || transferDone || hold_hit;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (win_found) begin
          grant_d[win_idx] = 1'b1;
          idx_d            = win_idx;
          cnt_d            = '0;
          state_d          = StGrant;
          if (32'(win_idx) == INPUTS - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = win_idx + 1'b1;
          end
        end
      end
      StGrant: begin
        if (release_grant) begin
          grant_d   = '0;
          state_d   = StGap;
          // Only a pure hold-limit release counts as a timeout.
          timeout_d = hold_hit && request[idx_q] && !transferDone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= |grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant      = grant_q;
  assign grantValid = valid_q;
  assign grantIndex = idx_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_select_arbiter.sv
// Scoreboard bench for select_arbiter (INPUTS=4, HOLD_LIMIT=5): stimulus queues expected
// grants, a negedge monitor checks each grant's value, index, length, gap and timeout.
module tb_select_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic       transferDone;
  logic [3:0] grant;
  logic       grantValid;
  logic [1:0] grantIndex;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] g;
    int         idx;
    int         len;
    bit         to;
    int         gap;   // zero cycles before this grant; -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  select_arbiter #(
    .INPUTS       (4),
    .HOLD_LIMIT   (5),
    .COUNTER_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (request),
    .transferDone(transferDone),
    .grant       (grant),
    .grantValid  (grantValid),
    .grantIndex  (grantIndex),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input int idx, input int len, input bit to,
                      input int gap);
    exp_t e;
    e.g = g; e.idx = idx; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input bit nz);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((grant != 4'b0) == nz) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_grant: grant stuck at %b, expected nonzero=%0d", grant, nz);
    end
  endtask

  // Owner keeps its request for `hold` edges after the grant is seen, then drops it.
  task automatic serve(input int b, input int hold);
    wait_grant(1'b1);
    repeat (hold) @(posedge clk);
    #1 request[b] = 1'b0;
    wait_grant(1'b0);
  endtask

  // Monitor
  initial begin
    logic [3:0] prev;
    exp_t       cur;
    int         len;
    int         gap;
    prev = '0;
    len  = 0;
    gap  = 0;
    cur  = '{g: '0, idx: 0, len: 0, to: 1'b0, gap: -1};
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("valid_vs_grant", {31'b0, grantValid}, {31'b0, |grant});
        check("onehot", {31'b0, $countones(grant) > 1}, 32'd0);
      end
      if (grant != 0 && prev == 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got %b, expected none", grant);
          cur = '{g: grant, idx: 0, len: -1, to: 1'b0, gap: -1};
        end else begin
          cur = exp_q.pop_front();
          check("grant", {28'b0, grant}, {28'b0, cur.g});
          check("grantIndex", {30'b0, grantIndex}, cur.idx);
          if (cur.gap >= 0) check("gap_cycles", gap, cur.gap);
        end
        len = 1;
      end else if (grant != 0) begin
        if (grant != prev) check("grant_stable", {28'b0, grant}, {28'b0, prev});
        len++;
      end else if (prev != 0) begin
        if (cur.len >= 0) check("grant_length", len, cur.len);
        check("timeout_at_fall", {31'b0, timeout}, {31'b0, cur.to});
        gap = 1;
      end else begin
        if (rst_n) check("timeout_idle", {31'b0, timeout}, 32'd0);
        gap++;
      end
      prev = grant;
    end
  end

  // Stimulus
  initial begin
    rst_n        = 1'b0;
    request      = '0;
    transferDone = 1'b0;

    // 1: reset then idle
    repeat (3) @(posedge clk);
    check("reset_outputs", {24'b0, grant, grantValid, grantIndex, timeout}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs", {24'b0, grant, grantValid, grantIndex, timeout}, 32'd0);
    end

    // 2: round-robin fairness, each owner drops 3 edges after its grant
    push(4'b0001, 0, 4, 1'b0, -1);
    push(4'b0010, 1, 4, 1'b0, 2);
    push(4'b0100, 2, 4, 1'b0, 2);
    push(4'b1000, 3, 4, 1'b0, 2);
    push(4'b0001, 0, 4, 1'b0, 2);
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(1'b1);
      repeat (3) @(posedge clk);
      #1 request[k % 4] = 1'b0;
      wait_grant(1'b0);
      if (k < 4) request[k % 4] = 1'b1;
      else       request = '0;
    end

    // 3: wrap and skip (last grant to input 2, pointer 3)
    push(4'b0100, 2, 2, 1'b0, -1);
    request = 4'b0100;
    serve(2, 1);
    push(4'b0001, 0, 2, 1'b0, 2);
    push(4'b0100, 2, 2, 1'b0, 2);
    request = 4'b0101;
    serve(0, 1);
    serve(2, 1);

    // 4: no pre-emption, release by transferDone
    push(4'b0010, 1, 3, 1'b0, -1);
    push(4'b1000, 3, 2, 1'b0, 2);
    request = 4'b0010;
    wait_grant(1'b1);
    @(posedge clk);
    #1 request[3] = 1'b1;
    @(posedge clk);
    #1 transferDone = 1'b1;
    @(posedge clk);
    #1 transferDone = 1'b0;
    request[1] = 1'b0;
    serve(3, 1);

    // 5: hold limit; input 2 never drops, input 0 must get a turn in between
    push(4'b0100, 2, 5, 1'b1, -1);
    push(4'b0001, 0, 2, 1'b0, 2);
    push(4'b0100, 2, 5, 1'b1, 2);
    request = 4'b0100;
    wait_grant(1'b1);
    request[0] = 1'b1;
    wait_grant(1'b0);
    serve(0, 1);
    wait_grant(1'b1);
    wait_grant(1'b0);
    request = '0;

    // 6: asynchronous reset mid-grant, pointer returns to 0
    push(4'b0010, 1, 2, 1'b0, -1);
    request = 4'b0010;
    wait_grant(1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_grant", {28'b0, grant}, 32'd0);
    check("async_rst_valid", {31'b0, grantValid}, 32'd0);
    check("async_rst_index", {30'b0, grantIndex}, 32'd0);
    request = 4'b1010;
    repeat (2) @(posedge clk);
    push(4'b0010, 1, 2, 1'b0, -1);
    push(4'b1000, 3, 2, 1'b0, 2);
    #1 rst_n = 1'b1;
    serve(1, 1);
    serve(3, 1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
